avi_info_frame_decoder: RTL

//  Receive-side counterpart of the AVI InfoFrame packet generator. Takes a decoded HDMI data-island

---
 rtl/avi_info_frame_decoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/avi_info_frame_decoder.sv
// AVI InfoFrame receiver: checks the header and checksum of a depacketised data-island byte stream
// and holds the last good AVI fields. Optional bar decode is enabled with `define AVI_BAR_DECODE_EN.
module avi_info_frame_decoder #(
  parameter logic [7:0] EXPECTED_VERSION = 8'd2,
  parameter int         MAX_GAP          = 64
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        in_start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        frame_ok,
  output logic        checksum_err,
  output logic        header_err,
  output logic        abort,
  output logic [7:0]  vic,
  output logic [1:0]  video_format,
  output logic [1:0]  colorimetry,
  output logic [1:0]  picture_aspect,
  output logic [3:0]  active_aspect,
  output logic        it_content,
  output logic [1:0]  rgb_quant,
  output logic [1:0]  ycc_quant,
  output logic [1:0]  content_type,
  output logic [3:0]  pixel_rep,
  output logic [15:0] bar_top,
  output logic [15:0] bar_bottom,
  output logic [15:0] bar_left,
  output logic [15:0] bar_right,
  output logic [1:0]  state_dbg
);
  localparam int GW = $clog2(MAX_GAP + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_PAY = 2'd2, S_CHK = 2'd3} state_t;
  state_t state, state_nxt;

  // Handshake: a byte is consumed on every cycle with in_valid high (no backpressure);
  // in_start is only meaningful together with in_valid and always marks HB0.
  logic [4:0]    byte_idx;
  logic [7:0]    sum8;
  logic [GW-1:0] gap_cnt;
  logic          hdr_bad_q;
  logic [1:0]    sh_vf;
  logic [7:0]    sh_pb2, sh_pb4, sh_pb5;
  logic          sh_it;
  logic [1:0]    sh_rgbq;

  logic restart, in_pkt, take_byte, hdr_last, hdr_bad_now, gap_expire;
  logic frame_ok_nxt, checksum_err_nxt, header_err_nxt, abort_nxt;

  assign restart     = in_valid & in_start;
  assign in_pkt      = (state == S_HDR) || (state == S_PAY);
  assign take_byte   = in_pkt & in_valid & ~in_start;
  assign hdr_last    = (state == S_HDR) & take_byte & (byte_idx == 5'd2);
  assign hdr_bad_now = hdr_bad_q | (in_byte[4:0] != 5'd13);
  assign gap_expire  = in_pkt & ~in_valid & (gap_cnt == GW'(MAX_GAP - 1));
  assign state_dbg   = state;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (restart) state_nxt = S_HDR;
      S_HDR, S_PAY: begin
        if (restart)                                           state_nxt = S_HDR;
        else if (hdr_last)                                     state_nxt = hdr_bad_now ? S_IDLE : S_PAY;
        else if (take_byte && state == S_PAY && byte_idx == 5'd30) state_nxt = S_CHK;
        else if (gap_expire)                                   state_nxt = S_IDLE;
      end
      S_CHK:  state_nxt = restart ? S_HDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A restart during CHK is not an abort: the finished packet's verdict still goes out.
  always_comb begin
    frame_ok_nxt     = (state == S_CHK) && (sum8 == 8'd0);
    checksum_err_nxt = (state == S_CHK) && (sum8 != 8'd0);
    header_err_nxt   = hdr_last & hdr_bad_now;
    abort_nxt        = in_pkt & (restart | gap_expire);
  end

`ifdef AVI_BAR_DECODE_EN
  logic [7:0] sh_bar [8];
  logic       sh_bar_en;
  logic [2:0] bar_sel;
  assign bar_sel = byte_idx[2:0] - 3'd1;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) sh_bar[i] <= 8'd0;
      sh_bar_en  <= 1'b0;
      bar_top    <= 16'd0;
      bar_bottom <= 16'd0;
      bar_left   <= 16'd0;
      bar_right  <= 16'd0;
    end else begin
      if (take_byte && byte_idx == 5'd4) sh_bar_en <= (in_byte[3:2] != 2'b00);
      if (take_byte && byte_idx >= 5'd9 && byte_idx <= 5'd16) sh_bar[bar_sel] <= in_byte;
      if (frame_ok_nxt) begin
        bar_top    <= sh_bar_en ? {sh_bar[1], sh_bar[0]} : 16'd0;
        bar_bottom <= sh_bar_en ? {sh_bar[3], sh_bar[2]} : 16'd0;
        bar_left   <= sh_bar_en ? {sh_bar[5], sh_bar[4]} : 16'd0;
        bar_right  <= sh_bar_en ? {sh_bar[7], sh_bar[6]} : 16'd0;
      end
    end
  end
`else
  assign bar_top    = 16'd0;
  assign bar_bottom = 16'd0;
  assign bar_left   = 16'd0;
  assign bar_right  = 16'd0;
`endif

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      frame_ok       <= 1'b0;
      checksum_err   <= 1'b0;
      header_err     <= 1'b0;
      abort          <= 1'b0;
      byte_idx       <= 5'd0;
      sum8           <= 8'd0;
      gap_cnt        <= '0;
      hdr_bad_q      <= 1'b0;
      sh_vf          <= 2'd0;
      sh_pb2         <= 8'h09;
      sh_it          <= 1'b0;
      sh_rgbq        <= 2'd0;
      sh_pb4         <= 8'd0;
      sh_pb5         <= 8'd0;
      vic            <= 8'd0;
      video_format   <= 2'd0;
      colorimetry    <= 2'd0;
      picture_aspect <= 2'd0;
      active_aspect  <= 4'b1001;
      it_content     <= 1'b0;
      rgb_quant      <= 2'd0;
      ycc_quant      <= 2'd0;
      content_type   <= 2'd0;
      pixel_rep      <= 4'd0;
    end else begin
      frame_ok     <= frame_ok_nxt;
      checksum_err <= checksum_err_nxt;
      header_err   <= header_err_nxt;
      abort        <= abort_nxt;

      if (restart) begin
        byte_idx  <= 5'd1;
        sum8      <= in_byte;
        hdr_bad_q <= (in_byte != 8'h82);
        gap_cnt   <= '0;
      end else if (take_byte) begin
        byte_idx <= (byte_idx == 5'd30) ? 5'd0 : byte_idx + 5'd1;
        gap_cnt  <= '0;
        // Only HB0..HB2 and PB0..PB13 contribute to the checksum.
        if (byte_idx <= 5'd16) sum8 <= sum8 + in_byte;
        if (byte_idx == 5'd1) hdr_bad_q <= hdr_bad_q | (in_byte != EXPECTED_VERSION);
        case (byte_idx)
          5'd4: sh_vf <= in_byte[6:5];
          5'd5: sh_pb2 <= in_byte;
          5'd6: begin sh_it <= in_byte[7]; sh_rgbq <= in_byte[3:2]; end
          5'd7: sh_pb4 <= in_byte;
          5'd8: sh_pb5 <= in_byte;
          default: ;
        endcase
      end else if (in_pkt && !gap_expire) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end

      if (frame_ok_nxt) begin
        vic            <= sh_pb4;
        video_format   <= sh_vf;
        colorimetry    <= sh_pb2[7:6];
        picture_aspect <= sh_pb2[5:4];
        active_aspect  <= sh_pb2[3:0];
        it_content     <= sh_it;
        rgb_quant      <= sh_rgbq;
        ycc_quant      <= sh_pb5[7:6];
        content_type   <= sh_pb5[5:4];
        pixel_rep      <= sh_pb5[3:0];
      end
    end
  end
endmodule
